dma_arbiter: RTL and testbench

//  Shares the processor board's single DMA port (dma_req/dma_ack, dma_adr18, dma_stb) between NREQ bus masters.

---
 rtl/dma_arbiter.sv | 90 +++++++++
 tb/tb_dma_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// dma_arbiter: round-robin sharing of the CPU board DMA port between NREQ bus masters
module dma_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TMO  = 255
) (
  input  logic                 clk_p,
  input  logic                 dclo,
  input  logic [NREQ-1:0]      m_req,
  output logic [NREQ-1:0]      m_gnt,
  input  logic [18*NREQ-1:0]   m_adr18,
  input  logic [NREQ-1:0]      m_stb,
  input  logic [NREQ-1:0]      m_we,
  input  logic [2*NREQ-1:0]    m_sel,
  output logic [NREQ-1:0]      m_ack,
  output logic                 dma_req,
  input  logic                 dma_ack,
  output logic [17:0]          dma_adr18,
  output logic                 dma_stb,
  output logic                 dma_we,
  output logic [1:0]           dma_sel,
  input  logic                 ram_ack
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = MAX_BURST > 0 ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BW-1:0] BSAT = MAX_BURST > 0 ? BW'(MAX_BURST) : '1;
  typedef enum logic [1:0] {IDLE, REQ, GRANT, REL} state_t;
  state_t state;
  logic [IW-1:0] win, ptr, pick, idx, win_nxt;
  logic [BW-1:0] burst;
  logic [7:0] idle;
  logic grant, w_req, w_stb, xfer, tmo, burst_hit, leave;
  assign grant     = state == GRANT;
  assign w_req     = m_req[win];
  assign w_stb     = m_stb[win];
  assign dma_req   = state == REQ || grant;
  assign m_gnt     = grant ? NREQ'(1) << win : '0;
  assign dma_stb   = grant & dma_ack & w_stb;
  assign dma_we    = grant & m_we[win];
  assign dma_sel   = grant ? m_sel[2*int'(win) +: 2] : '0;
  assign dma_adr18 = grant ? m_adr18[18*int'(win) +: 18] : '0;
  assign xfer      = dma_stb & ram_ack;
  assign m_ack     = {NREQ{xfer}} & m_gnt;
  assign tmo       = idle == 8'(IDLE_TMO);
  assign burst_hit = MAX_BURST != 0 && burst == BSAT;
  assign leave     = !dma_ack || !w_req || ((burst_hit || tmo) && !w_stb);
  assign win_nxt   = int'(win) == NREQ - 1 ? '0 : win + 1'b1;
  // first requester at or above the rotation pointer, wrapping around
  always_comb begin
    pick = ptr;
    idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k >= NREQ ? IW'(int'(ptr) + k - NREQ) : IW'(int'(ptr) + k);
      if (m_req[idx]) pick = idx;
    end
  end
  // handshake sequencer with burst and idle watchdogs; forced releases wait for strobe low
  always_ff @(posedge clk_p) begin
    if (dclo) begin
      state <= IDLE;
      win   <= '0;
      ptr   <= '0;
      burst <= '0;
      idle  <= '0;
    end else begin
      case (state)
        IDLE: if (|m_req) begin
          state <= REQ;
          win   <= pick;
        end
        REQ: if (!w_req) state <= REL;
        else if (dma_ack) begin
          state <= GRANT;
          burst <= '0;
          idle  <= '0;
        end
        GRANT: begin
          if (leave) state <= REL;
          if (xfer && burst != BSAT) burst <= burst + 1'b1;
          idle <= w_stb ? '0 : tmo ? idle : idle + 1'b1;
        end
        REL: begin
          ptr <= win_nxt;
          if (!dma_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed vectors plus CPU/memory/master models for two arbiter configurations
module tb_dma_arbiter;
  localparam int N = 4;
  typedef struct {
    int         pre;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [17:0] adr;
    logic       we;
    logic [1:0] sel;
  } vec_t;
  logic clk_p = 0;
  always #5 clk_p = ~clk_p;
  logic dclo [2];
  logic [N-1:0] m_req [2], m_gnt [2], m_stb [2], m_we [2], m_ack [2];
  logic [18*N-1:0] m_adr18 [2];
  logic [2*N-1:0] m_sel [2];
  logic dma_req [2], dma_ack [2], dma_stb [2], dma_we [2], ram_ack [2];
  logic [17:0] dma_adr18 [2];
  logic [1:0] dma_sel [2];
  int ack_tot [2], stb_limit [2], age [2], req_cnt [2], dly [2], gap [2], gcnt [2], trunc [2];
  int gorder [2][64], gacks [2][64];
  logic [N-1:0] pg [2];
  int n_chk = 0, n_fail = 0;

  dma_arbiter u0 (
    .clk_p(clk_p), .dclo(dclo[0]), .m_req(m_req[0]), .m_gnt(m_gnt[0]), .m_adr18(m_adr18[0]),
    .m_stb(m_stb[0]), .m_we(m_we[0]), .m_sel(m_sel[0]), .m_ack(m_ack[0]), .dma_req(dma_req[0]),
    .dma_ack(dma_ack[0]), .dma_adr18(dma_adr18[0]), .dma_stb(dma_stb[0]), .dma_we(dma_we[0]),
    .dma_sel(dma_sel[0]), .ram_ack(ram_ack[0])
  );
  dma_arbiter #(.MAX_BURST(2)) u1 (
    .clk_p(clk_p), .dclo(dclo[1]), .m_req(m_req[1]), .m_gnt(m_gnt[1]), .m_adr18(m_adr18[1]),
    .m_stb(m_stb[1]), .m_we(m_we[1]), .m_sel(m_sel[1]), .m_ack(m_ack[1]), .dma_req(dma_req[1]),
    .dma_ack(dma_ack[1]), .dma_adr18(dma_adr18[1]), .dma_stb(dma_stb[1]), .dma_we(dma_we[1]),
    .dma_sel(dma_sel[1]), .ram_ack(ram_ack[1])
  );

  // CPU board acks 3 cycles into a request, memory acks dly cycles into a strobe,
  // the granted master strobes until its transfer budget is used; grants and acks are logged
  initial begin
    logic [N-1:0] g, a;
    logic s, r;
    int w;
    for (int d = 0; d < 2; d++) begin
      m_stb[d] = '0;
      ram_ack[d] = 0;
      dma_ack[d] = 0;
      pg[d] = '0;
    end
    forever begin
      @(negedge clk_p);
      for (int d = 0; d < 2; d++) begin
        g = m_gnt[d];
        a = m_ack[d];
        s = dma_stb[d];
        r = dma_req[d];
        w = 0;
        for (int i = 0; i < N; i++) if (g[i]) w = i;
        if (g != 0 && pg[d] == 0) begin
          gorder[d][gcnt[d] % 64] = w;
          gacks[d][gcnt[d] % 64] = 0;
          gcnt[d]++;
        end
        if (a != 0) begin
          ack_tot[d]++;
          if (gcnt[d] > 0) gacks[d][(gcnt[d] - 1) % 64]++;
        end
        if (g == 0 && pg[d] != 0 && (m_stb[d] & pg[d]) != 0) trunc[d]++;
        pg[d] = g;
        req_cnt[d] = r ? req_cnt[d] + 1 : 0;
        dma_ack[d] = req_cnt[d] >= 3;
        if (ram_ack[d]) begin
          ram_ack[d] = 0;
          age[d] = 0;
        end else if (s) begin
          age[d]++;
          ram_ack[d] = age[d] >= dly[d];
        end else age[d] = 0;
        m_stb[d] = (g != 0 && ack_tot[d] < stb_limit[d] && !(gap[d] != 0 && a != 0)) ? g : '0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk_p);
      #1;
    end
  endtask

  task automatic reset_all();
    dclo[0] = 1;
    dclo[1] = 1;
    tick(2);
    dclo[0] = 0;
    dclo[1] = 0;
  endtask

  task automatic wait_gnt(input int d);
    int t;
    t = 0;
    while (m_gnt[d] == 0 && t < 50) begin
      tick();
      t++;
    end
    if (m_gnt[d] == 0) chk("grant_timeout", 32'(m_gnt[d]), 32'hf);
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while ((dma_req[d] || m_gnt[d] != 0) && t < 400) begin
      tick();
      t++;
    end
    if (dma_req[d]) chk("release_timeout", 32'(dma_req[d]), 0);
    tick(2);
  endtask

  initial begin
    vec_t tbl [8];
    int t, base, gb, tb;
    tbl[0] = '{-1, 4'b1010, 4'b0010, 18'h02222, 1'b1, 2'd1};
    tbl[1] = '{-1, 4'b1000, 4'b1000, 18'h04444, 1'b1, 2'd3};
    tbl[2] = '{ 1, 4'b1011, 4'b1000, 18'h04444, 1'b1, 2'd3};
    tbl[3] = '{ 3, 4'b0110, 4'b0010, 18'h02222, 1'b1, 2'd1};
    tbl[4] = '{ 2, 4'b0101, 4'b0001, 18'h01111, 1'b0, 2'd0};
    tbl[5] = '{ 0, 4'b1100, 4'b0100, 18'h03333, 1'b0, 2'd2};
    tbl[6] = '{ 3, 4'b1111, 4'b0001, 18'h01111, 1'b0, 2'd0};
    tbl[7] = '{ 2, 4'b0110, 4'b0010, 18'h02222, 1'b1, 2'd1};
    for (int d = 0; d < 2; d++) begin
      m_req[d] = '0;
      m_we[d] = 4'b1010;
      m_sel[d] = 8'b11_10_01_00;
      m_adr18[d] = {18'h04444, 18'h03333, 18'h02222, 18'h01111};
      dly[d] = 1;
      gap[d] = 1;
      stb_limit[d] = 0;
    end
    reset_all();
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outputs_%0d", d),
          32'({m_gnt[d], m_ack[d], dma_req[d], dma_stb[d], dma_we[d], dma_sel[d], dma_adr18[d]}), 0);

    // single master: request/ack latency, four transfers, release
    base = ack_tot[0];
    stb_limit[0] = base + 4;
    m_req[0] = 4'b0001;
    tick();
    chk("req_latency", 32'(dma_req[0]), 1);
    t = 0;
    while (!dma_ack[0] && t < 20) begin
      tick();
      t++;
    end
    chk("cpu_ack_delay", t, 2);
    chk("no_gnt_before_ack", 32'(m_gnt[0]), 0);
    tick();
    chk("gnt_latency", 32'(m_gnt[0]), 32'b0001);
    chk("adr_mux_m0", 32'(dma_adr18[0]), 32'h01111);
    t = 0;
    while (ack_tot[0] - base < 4 && t < 100) begin
      tick();
      t++;
    end
    tick(3);
    chk("m0_acks", ack_tot[0] - base, 4);
    chk("m0_still_granted", 32'(m_gnt[0]), 32'b0001);
    m_req[0] = '0;
    tick();
    chk("rel_dma_req", 32'(dma_req[0]), 0);
    chk("rel_gnt", 32'(m_gnt[0]), 0);
    tick();
    chk("rel_dma_ack_low", 32'(dma_ack[0]), 0);
    tick();
    chk("idle_dma_req", 32'(dma_req[0]), 0);

    // table: pointer position set by an optional prior grant, then the winner and mux outputs
    for (int v = 0; v < 8; v++) begin
      reset_all();
      stb_limit[0] = ack_tot[0];
      if (tbl[v].pre >= 0) begin
        m_req[0] = N'(1) << tbl[v].pre;
        wait_gnt(0);
        m_req[0] = '0;
        wait_idle(0);
      end
      m_req[0] = tbl[v].req;
      wait_gnt(0);
      chk($sformatf("tbl%0d_gnt", v), 32'(m_gnt[0]), 32'(tbl[v].gnt));
      chk($sformatf("tbl%0d_adr", v), 32'(dma_adr18[0]), 32'(tbl[v].adr));
      chk($sformatf("tbl%0d_we", v), 32'(dma_we[0]), 32'(tbl[v].we));
      chk($sformatf("tbl%0d_sel", v), 32'(dma_sel[0]), 32'(tbl[v].sel));
      m_req[0] = '0;
      wait_idle(0);
    end

    // all four requesting with MAX_BURST=2: rotation 0,1,2,3,0 with two acks each
    reset_all();
    gb = gcnt[1];
    stb_limit[1] = ack_tot[1] + 1000;
    m_req[1] = 4'b1111;
    t = 0;
    while (gcnt[1] - gb < 6 && t < 400) begin
      tick();
      t++;
    end
    m_req[1] = '0;
    stb_limit[1] = ack_tot[1];
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rot%0d_master", k), gorder[1][(gb + k) % 64], k % 4);
      chk($sformatf("rot%0d_acks", k), gacks[1][(gb + k) % 64], 2);
    end
    wait_idle(1);

    // master 2 idles: counter reaches 255 after 255 idle cycles, release on the following edge
    reset_all();
    stb_limit[0] = ack_tot[0];
    m_req[0] = 4'b0100;
    wait_gnt(0);
    chk("tmo_gnt_m2", 32'(m_gnt[0]), 32'b0100);
    m_req[0] = 4'b1100;
    t = 0;
    while (m_gnt[0] == 4'b0100 && t < 400) begin
      t++;
      tick();
    end
    chk("tmo_grant_cycles", t, 256);
    wait_gnt(0);
    chk("tmo_next_m3", 32'(m_gnt[0]), 32'b1000);
    m_req[0] = '0;
    wait_idle(0);

    // burst limit reached with a third strobe already up: it completes before release
    reset_all();
    dly[1] = 5;
    gap[1] = 0;
    base = ack_tot[1];
    gb = gcnt[1];
    tb = trunc[1];
    stb_limit[1] = base + 3;
    m_req[1] = 4'b0001;
    wait_gnt(1);
    t = 0;
    while (m_gnt[1] != 0 && t < 200) begin
      tick();
      t++;
    end
    m_req[1] = '0;
    chk("burst_acks_in_grant", gacks[1][gb % 64], 3);
    chk("burst_no_truncation", trunc[1] - tb, 0);
    wait_idle(1);
    dly[1] = 1;
    gap[1] = 1;

    // reset in the middle of a strobe, pointer back to 0 afterwards
    reset_all();
    stb_limit[0] = ack_tot[0];
    m_req[0] = 4'b0100;
    wait_gnt(0);
    m_req[0] = '0;
    wait_idle(0);
    dly[0] = 50;
    stb_limit[0] = ack_tot[0] + 100;
    m_req[0] = 4'b1000;
    wait_gnt(0);
    tick(2);
    chk("pre_reset_stb", 32'(dma_stb[0]), 1);
    dclo[0] = 1;
    tick();
    chk("reset_mid_grant",
        32'({m_gnt[0], m_ack[0], dma_req[0], dma_stb[0], dma_we[0], dma_sel[0], dma_adr18[0]}), 0);
    dclo[0] = 0;
    dly[0] = 1;
    stb_limit[0] = ack_tot[0];
    m_req[0] = 4'b1111;
    wait_gnt(0);
    chk("ptr_cleared", 32'(m_gnt[0]), 32'b0001);
    m_req[0] = '0;
    wait_idle(0);

    // master 1 withdraws during REQ: no grant and no ack
    reset_all();
    base = ack_tot[0];
    gb = gcnt[0];
    m_req[0] = 4'b0010;
    tick();
    chk("drop_req_raised", 32'(dma_req[0]), 1);
    m_req[0] = '0;
    tick();
    chk("drop_req_released", 32'(dma_req[0]), 0);
    tick(5);
    chk("drop_no_grant", gcnt[0] - gb, 0);
    chk("drop_no_ack", ack_tot[0] - base, 0);
    chk("drop_gnt_low", 32'(m_gnt[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
